// File: rtl/sha256_w_sched_ctrl.sv
// SHA-256 message schedule controller: loads a 512-bit block and streams W_0..W_{NUM_ROUNDS-1}
// over a valid/ready port, expanding words on the fly from a 16-word sliding window.
module sha256_w_sched_ctrl #(
    parameter int NUM_ROUNDS = 64
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         start_valid,
    output logic         start_ready,
    input  logic [511:0] block_in,
    input  logic         abort,
    output logic         wt_valid,
    input  logic         wt_ready,
    output logic [31:0]  wt,
    output logic [5:0]   round_idx,
    output logic         wt_last,
    output logic         done,
    output logic         busy,
    output logic         dbg_state
);
    // Handshake: a word moves when wt_valid and wt_ready are both high at a rising edge;
    // wt_valid never depends on wt_ready, and wt/round_idx hold while the consumer stalls.
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    state_t      r_state;
    logic [31:0] r_win [16];
    logic [5:0]  r_t;
    logic        r_wt_valid;
    logic        r_wt_last;
    logic        r_done;
    logic        r_busy;

    logic        w_xfer;
    logic [31:0] w_new;

    function automatic logic [31:0] f_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] f_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    assign w_xfer = r_wt_valid & wt_ready;
    assign w_new  = f_sigma0(r_win[1]) + r_win[9] + f_sigma1(r_win[14]) + r_win[0];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_t        <= '0;
            r_wt_valid <= 1'b0;
            r_wt_last  <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                r_win[k] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // abort in IDLE suppresses a simultaneous start
                    if (start_valid && !abort) begin
                        for (int k = 0; k < 16; k++) begin
                            r_win[k] <= block_in[511 - 32*k -: 32];
                        end
                        r_t        <= '0;
                        r_state    <= S_RUN;
                        r_wt_valid <= 1'b1;
                        r_wt_last  <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_state    <= S_IDLE;
                        r_wt_valid <= 1'b0;
                        r_wt_last  <= 1'b0;
                        r_busy     <= 1'b0;
                    end else if (w_xfer) begin
                        if (r_t == LAST_IDX) begin
                            r_state    <= S_IDLE;
                            r_wt_valid <= 1'b0;
                            r_wt_last  <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            for (int k = 0; k < 15; k++) begin
                                r_win[k] <= r_win[k+1];
                            end
                            r_win[15] <= w_new;
                            r_t       <= r_t + 6'd1;
                            r_wt_last <= ((r_t + 6'd1) == LAST_IDX);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_ready = (r_state == S_IDLE);
    assign wt_valid    = r_wt_valid;
    assign wt          = r_win[0];
    assign round_idx   = r_t;
    assign wt_last     = r_wt_last;
    assign done        = r_done;
    assign busy        = r_busy;
    assign dbg_state   = r_state;

endmodule
